// File: rtl/run_control_monitor_pkg.sv
// Shared types and constants for the run control / change monitor block.
package run_control_monitor_pkg;

    // Run sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Width of the channel index carried with each change record
    localparam int CH_IDX_W = 4;

    // Change detection is only armed once the core is out of reset
    function automatic logic state_observes(input state_t s);
        return (s == ST_RUN) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/run_control_monitor_arbiter.sv
// Fixed-priority arbiter: picks the lowest-index pending channel.
module run_control_monitor_arbiter
    import run_control_monitor_pkg::*;
#(
    parameter int CHANNELS = 1
) (
    input  logic [CHANNELS-1:0] pending,
    output logic                any_pending,
    output logic [CH_IDX_W-1:0] sel_idx
);

    // Scan high to low so the lowest set index is the last one written
    always_comb begin
        any_pending = 1'b0;
        sel_idx     = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (pending[c]) begin
                any_pending = 1'b1;
                sel_idx     = CH_IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/run_control_monitor.sv
// Sequences a multi-cycle reset to a core, bounds the run to a tick budget,
// and streams value changes of the observed buses as (channel, data, tick)
// records.
//
// Record handshake: chg_valid high means chg_ch/chg_data/chg_tick describe a
// pending change; the record is consumed on any rising clk edge where
// chg_valid && chg_ready. While chg_valid && !chg_ready the presented channel
// stays locked; its data/tick may be refreshed by a newer change on that same
// channel, which also raises the sticky overflow flag.
module run_control_monitor
    import run_control_monitor_pkg::*;
#(
    parameter int RESET_CYCLES = 3,
    parameter int TICKS        = 20000,
    parameter int TICK_W       = 32,
    parameter int WIDTH        = 32,
    parameter int CHANNELS     = 1,
    parameter int AUTO_START   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      cpu_reset,
    input  logic [CHANNELS*WIDTH-1:0] obs,
    output logic                      run_active,
    output logic                      done,
    output logic [TICK_W-1:0]         tick_count,
    output logic                      chg_valid,
    input  logic                      chg_ready,
    output logic [CH_IDX_W-1:0]       chg_ch,
    output logic [WIDTH-1:0]          chg_data,
    output logic [TICK_W-1:0]         chg_tick,
    output logic                      overflow,
    output state_t                    dbg_state
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    // Elaboration-time parameter sanity
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("run_control_monitor: CHANNELS must be 1..16");
    end
    if (RESET_CYCLES < 1 || TICKS < 1) begin : g_bad_counts
        $error("run_control_monitor: RESET_CYCLES and TICKS must be >= 1");
    end
    if ($clog2(TICKS) > TICK_W) begin : g_bad_tick_w
        $error("run_control_monitor: TICKS-1 does not fit in TICK_W bits");
    end

    // ---------------- reset release synchroniser ----------------
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    // Shift ones in after release; assertion is immediate
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // Async clear, sync release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    // ---------------- run FSM ----------------
    state_t              state_q, state_d;
    logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                auto_done_q, auto_done_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                run_active_q, run_active_d;
    logic                done_q, done_d;

    // Next-state, counters and registered output decode
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        tick_d      = tick_q;
        auto_done_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if ((AUTO_START != 0 && !auto_done_q) || start) begin
                    state_d   = ST_RST;
                    rst_cnt_d = '0;
                    tick_d    = '0;
                end
            end
            ST_RST: begin
                if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    tick_d  = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (tick_q == TICK_W'(TICKS - 1)) state_d = ST_DONE;
                else                              tick_d  = tick_q + 1'b1;
            end
            default: begin
                if (start) begin
                    state_d   = ST_RST;
                    rst_cnt_d = '0;
                    tick_d    = '0;
                end
            end
        endcase
        cpu_reset_d  = (state_d == ST_IDLE) || (state_d == ST_RST);
        run_active_d = (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);
    end

    // FSM state and its registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rst_cnt_q    <= '0;
            tick_q       <= '0;
            auto_done_q  <= 1'b0;
            cpu_reset_q  <= 1'b1;
            run_active_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            tick_q       <= tick_d;
            auto_done_q  <= auto_done_d;
            cpu_reset_q  <= cpu_reset_d;
            run_active_q <= run_active_d;
            done_q       <= done_d;
        end
    end

    // ---------------- change detection ----------------
    logic [WIDTH-1:0]    obs_q    [CHANNELS];
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    data_q   [CHANNELS];
    logic [WIDTH-1:0]    data_d   [CHANNELS];
    logic [TICK_W-1:0]   ctick_q  [CHANNELS];
    logic [TICK_W-1:0]   ctick_d  [CHANNELS];
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic                overflow_q, overflow_d;
    logic                lock_q, lock_d;
    logic [CH_IDX_W-1:0] lock_ch_q, lock_ch_d;
    logic                arb_valid;
    logic [CH_IDX_W-1:0] arb_idx;
    logic [CH_IDX_W-1:0] sel_ch;
    logic                accept;
    logic                entering_rst;

    run_control_monitor_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .pending     (pending_q),
        .any_pending (arb_valid),
        .sel_idx     (arb_idx)
    );

    // A channel shown while stalled stays shown until accepted
    assign sel_ch       = lock_q ? lock_ch_q : arb_idx;
    assign accept       = arb_valid && chg_ready;
    assign entering_rst = (state_d == ST_RST) && (state_q != ST_RST);

    // Pending/shadow/record update; a new change beats a same-cycle accept
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        lock_d     = 1'b0;
        lock_ch_d  = lock_ch_q;
        for (int c = 0; c < CHANNELS; c++) begin
            shadow_d[c] = shadow_q[c];
            data_d[c]   = data_q[c];
            ctick_d[c]  = ctick_q[c];
        end
        if (entering_rst) begin
            pending_d  = '0;
            overflow_d = 1'b0;
            for (int c = 0; c < CHANNELS; c++) shadow_d[c] = obs[c*WIDTH +: WIDTH];
        end else begin
            lock_d    = arb_valid && !chg_ready;
            lock_ch_d = sel_ch;
            for (int c = 0; c < CHANNELS; c++) begin
                if (accept && sel_ch == CH_IDX_W'(c)) pending_d[c] = 1'b0;
                if (state_q == ST_RST) begin
                    shadow_d[c] = obs_q[c];
                end else if (state_observes(state_q) && obs_q[c] != shadow_q[c]) begin
                    if (pending_q[c] && !(accept && sel_ch == CH_IDX_W'(c))) overflow_d = 1'b1;
                    pending_d[c] = 1'b1;
                    data_d[c]    = obs_q[c];
                    ctick_d[c]   = tick_q;
                    shadow_d[c]  = obs_q[c];
                end
            end
        end
    end

    // Observation pipeline, shadows, per-channel records and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
            lock_q     <= 1'b0;
            lock_ch_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                obs_q[c]    <= '0;
                shadow_q[c] <= '0;
                data_q[c]   <= '0;
                ctick_q[c]  <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            lock_q     <= lock_d;
            lock_ch_q  <= lock_ch_d;
            for (int c = 0; c < CHANNELS; c++) begin
                obs_q[c]    <= obs[c*WIDTH +: WIDTH];
                shadow_q[c] <= shadow_d[c];
                data_q[c]   <= data_d[c];
                ctick_q[c]  <= ctick_d[c];
            end
        end
    end

    // Present the selected channel's record
    always_comb begin
        chg_data = '0;
        chg_tick = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel_ch == CH_IDX_W'(c)) begin
                chg_data = data_q[c];
                chg_tick = ctick_q[c];
            end
        end
    end

    assign chg_valid  = arb_valid;
    assign chg_ch     = sel_ch;
    assign overflow   = overflow_q;
    assign cpu_reset  = cpu_reset_q;
    assign run_active = run_active_q;
    assign done       = done_q;
    assign tick_count = tick_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_run_control_monitor.sv
// Directed bench for run_control_monitor: 4 channels, TICKS=20, RESET_CYCLES=3.
module tb_run_control_monitor;
    import run_control_monitor_pkg::*;

    localparam int W  = 32;
    localparam int TW = 32;
    localparam int CH = 4;

    logic            clk;
    logic            reset;
    logic            start;
    logic            cpu_reset;
    logic [CH*W-1:0] obs;
    logic            run_active;
    logic            done;
    logic [TW-1:0]   tick_count;
    logic            chg_valid;
    logic            chg_ready;
    logic [3:0]      chg_ch;
    logic [W-1:0]    chg_data;
    logic [TW-1:0]   chg_tick;
    logic            overflow;
    state_t          dbg_state;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int cyc_fall;
    int n;
    int rst_len;

    run_control_monitor #(
        .RESET_CYCLES (3),
        .TICKS        (20),
        .TICK_W       (TW),
        .WIDTH        (W),
        .CHANNELS     (CH),
        .AUTO_START   (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cpu_reset  (cpu_reset),
        .obs        (obs),
        .run_active (run_active),
        .done       (done),
        .tick_count (tick_count),
        .chg_valid  (chg_valid),
        .chg_ready  (chg_ready),
        .chg_ch     (chg_ch),
        .chg_data   (chg_data),
        .chg_tick   (chg_tick),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    // Clock and free-running cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; obs = '0; chg_ready = 1'b1;
        step(3);
        // Reset values
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_run_active", run_active, 0);
        chk("rst_done", done, 0);
        chk("rst_tick", tick_count, 0);
        chk("rst_chg_valid", chg_valid, 0);
        chk("rst_overflow", overflow, 0);

        // Auto start: 3 cycles of RST, then RUN
        reset = 1'b1;
        n = 0;
        while (dbg_state !== ST_RST && n < 20) begin step(1); n++; end
        chk("auto_enter_rst", dbg_state === ST_RST, 1);
        rst_len = 0;
        while (dbg_state === ST_RST && rst_len < 20) begin
            chk("rst_cpu_reset_high", cpu_reset, 1);
            rst_len++;
            step(1);
        end
        chk("rst_len", rst_len, 3);
        cyc_fall = cyc;
        chk("run_cpu_reset_low", cpu_reset, 0);
        chk("run_active", run_active, 1);
        chk("run_tick0", tick_count, 0);

        // Single change on ch0 at tick 4: record stamped one tick later
        step(4);
        chk("tick4", tick_count, 4);
        obs[0*W +: W] = 32'd5;
        step(1);
        chk("lat1_no_valid", chg_valid, 0);
        step(1);
        chk("ch0_valid", chg_valid, 1);
        chk("ch0_ch", chg_ch, 0);
        chk("ch0_data", chg_data, 5);
        chk("ch0_tick", chg_tick, 5);
        step(1);
        chk("ch0_accepted", chg_valid, 0);

        // ch1 and ch3 change together at tick 7
        obs[1*W +: W] = 32'h11;
        obs[3*W +: W] = 32'h33;
        step(2);
        chk("dual_first_ch", chg_ch, 1);
        chk("dual_first_data", chg_data, 32'h11);
        chk("dual_first_tick", chg_tick, 8);
        step(1);
        chk("dual_second_valid", chg_valid, 1);
        chk("dual_second_ch", chg_ch, 3);
        chk("dual_second_data", chg_data, 32'h33);
        chk("dual_second_tick", chg_tick, 8);
        step(1);
        chk("dual_drained", chg_valid, 0);

        // Run ends 20 cycles after cpu_reset dropped
        n = 0;
        while (done !== 1'b1 && n < 60) begin step(1); n++; end
        chk("done_high", done, 1);
        chk("done_latency", cyc - cyc_fall, 20);
        chk("done_tick", tick_count, 19);
        chk("done_run_active", run_active, 0);
        chk("done_cpu_reset", cpu_reset, 0);

        // Stalled consumer: ch0 goes 1 then 2 -> overflow, one record of 2
        chg_ready = 1'b0;
        obs[0*W +: W] = 32'd1;
        step(1);
        obs[0*W +: W] = 32'd2;
        step(1);
        chk("ovf_first_data", chg_data, 1);
        chk("ovf_not_yet", overflow, 0);
        step(1);
        chk("ovf_set", overflow, 1);
        chk("ovf_valid", chg_valid, 1);
        chk("ovf_ch", chg_ch, 0);
        chk("ovf_data", chg_data, 2);
        chk("ovf_tick", chg_tick, 19);
        chg_ready = 1'b1;
        step(1);
        chk("ovf_single_record", chg_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // Start in DONE restarts the run and clears overflow
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("restart_rst", dbg_state === ST_RST, 1);
        chk("restart_cpu_reset", cpu_reset, 1);
        chk("restart_tick", tick_count, 0);
        chk("restart_overflow", overflow, 0);
        chk("restart_done", done, 0);
        rst_len = 1;
        step(1);
        while (dbg_state === ST_RST && rst_len < 20) begin rst_len++; step(1); end
        chk("restart_rst_len", rst_len, 3);
        step(2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("start_in_run_ignored", dbg_state === ST_RUN, 1);
        chk("start_in_run_tick", tick_count, 3);
        chk("no_record_for_reset_value", chg_valid, 0);

        // Reset mid-run with a record in flight
        step(3);
        obs[2*W +: W] = 32'h22;
        chg_ready = 1'b0;
        step(4);
        chk("midrun_tick10", tick_count, 10);
        chk("midrun_inflight", chg_valid, 1);
        chk("midrun_inflight_ch", chg_ch, 2);
        reset = 1'b0;
        #1;
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_run_active", run_active, 0);
        chk("midrst_tick", tick_count, 0);
        chk("midrst_valid", chg_valid, 0);
        chk("midrst_done", done, 0);
        step(2);
        reset = 1'b1;
        chg_ready = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 80) begin step(1); n++; end
        chk("rerun_done", done, 1);
        chk("rerun_tick", tick_count, 19);
        chk("rerun_no_records", chg_valid, 0);
        chk("rerun_overflow", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
